// File: rtl/alu_a_hazard_ctrl.sv
// Operand-A hazard controller: tracks the EX and MEM producers, stalls one
// cycle on load-use, and selects the registered forwarding source for EX.
module alu_a_hazard_ctrl #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_src_a,
    input  logic               id_src_a_use,
    input  logic [RADDR_W-1:0] id_dst,
    input  logic               id_dst_we,
    input  logic               id_is_load,
    input  logic               flush,
    output logic               stall,
    output logic [1:0]         ex_fwd_sel,
    output logic [15:0]        stall_cnt
);

    // Operand width is carried for interface compatibility; this block only
    // moves register addresses, so a nonsensical width is the only concern.
    if (DATA_W < 1) begin : g_bad_data_w
    end

    typedef struct packed {
        logic               we;
        logic [RADDR_W-1:0] dst;
        logic               load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    sb_entry_t  e_q;
    sb_entry_t  m_q;
    sb_entry_t  id_entry;
    fwd_sel_e   fwd_q;
    fwd_sel_e   fwd_d;
    logic [15:0] stall_cnt_q;

    logic issue;
    logic e_hit;
    logic m_hit;

    // Entries with we = 0 never match, whatever dst holds.
    assign e_hit = id_src_a_use & e_q.we & (e_q.dst == id_src_a);
    assign m_hit = id_src_a_use & m_q.we & (m_q.dst == id_src_a);

    assign stall = id_valid & e_hit & e_q.load & ~flush;
    assign issue = id_valid & ~stall;

    assign id_entry = '{we: id_dst_we, dst: id_dst, load: id_is_load};

    // NOTE: every signal driven from always_comb gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        fwd_d = FWD_REG;
        if (issue && !flush) begin
            // The younger producer in EX takes priority over the one in MEM.
            if (e_hit && !e_q.load) begin
                fwd_d = FWD_MEM;
            end else if (m_hit) begin
                fwd_d = FWD_WB;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so that m_q <= e_q
    // captures the pre-edge value of e_q, modelling a real pipeline shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q   <= '0;
            m_q   <= '0;
            fwd_q <= FWD_REG;
        end else if (flush) begin
            e_q   <= '0;
            m_q   <= '0;
            fwd_q <= FWD_REG;
        end else begin
            e_q   <= issue ? id_entry : '0;
            m_q   <= e_q;
            fwd_q <= fwd_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign ex_fwd_sel = fwd_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_alu_a_hazard_ctrl.sv
// Directed self-checking bench for alu_a_hazard_ctrl: forwarding distances,
// load-use stall, flush, counter saturation and asynchronous reset.
module tb_alu_a_hazard_ctrl;

    localparam int RADDR_W = 4;

    logic               clk;
    logic               rst;
    logic               id_valid;
    logic [RADDR_W-1:0] id_src_a;
    logic               id_src_a_use;
    logic [RADDR_W-1:0] id_dst;
    logic               id_dst_we;
    logic               id_is_load;
    logic               flush;
    logic               stall;
    logic [1:0]         ex_fwd_sel;
    logic [15:0]        stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    alu_a_hazard_ctrl #(.DATA_W(16), .RADDR_W(RADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src_a     (id_src_a),
        .id_src_a_use (id_src_a_use),
        .id_dst       (id_dst),
        .id_dst_we    (id_dst_we),
        .id_is_load   (id_is_load),
        .flush        (flush),
        .stall        (stall),
        .ex_fwd_sel   (ex_fwd_sel),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] src, input logic use_a,
                          input logic [3:0] dst, input logic we, input logic ld);
        id_valid     = v;
        id_src_a     = src;
        id_src_a_use = use_a;
        id_dst       = dst;
        id_dst_we    = we;
        id_is_load   = ld;
        #1;
    endtask

    task automatic drain();
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        flush = 1'b0;
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        #2;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b expected 0", stall);
        end
        n_checks++;
        if (ex_fwd_sel !== 2'b00) begin
            n_fail++; $display("FAIL reset_fwd: got %b expected 00", ex_fwd_sel);
        end
        n_checks++;
        if (stall_cnt !== 16'h0000) begin
            n_fail++; $display("FAIL reset_cnt: got %h expected 0000", stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++;
        if (ex_fwd_sel !== 2'b00 || stall_cnt !== 16'h0000) begin
            n_fail++; $display("FAIL post_reset_idle: got fwd=%b cnt=%h expected 00/0000",
                               ex_fwd_sel, stall_cnt);
        end
    endtask

    task automatic test_alu_to_alu();
        drain();
        set_id(1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);   // ADD -> R3
        tick();
        n_checks++;
        if (ex_fwd_sel !== 2'b00) begin
            n_fail++; $display("FAIL alu_first_fwd: got %b expected 00", ex_fwd_sel);
        end
        set_id(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0);   // SUB reads R3
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL alu_stall: got %b expected 0", stall);
        end
        tick();
        n_checks++;
        if (ex_fwd_sel !== 2'b01) begin
            n_fail++; $display("FAIL alu_fwd: got %b expected 01", ex_fwd_sel);
        end
    endtask

    task automatic test_distance_two();
        drain();
        set_id(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);   // write R5
        tick();
        set_id(1'b1, 4'd1, 1'b1, 4'd6, 1'b1, 1'b0);   // unrelated
        tick();
        set_id(1'b1, 4'd5, 1'b1, 4'd7, 1'b1, 1'b0);   // read R5
        tick();
        n_checks++;
        if (ex_fwd_sel !== 2'b10) begin
            n_fail++; $display("FAIL dist2_fwd: got %b expected 10", ex_fwd_sel);
        end

        drain();
        set_id(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);   // write R5
        tick();
        set_id(1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0);   // write R5 again
        tick();
        set_id(1'b1, 4'd5, 1'b1, 4'd7, 1'b1, 1'b0);   // read R5
        tick();
        n_checks++;
        if (ex_fwd_sel !== 2'b01) begin
            n_fail++; $display("FAIL dist2_younger_fwd: got %b expected 01", ex_fwd_sel);
        end
    endtask

    task automatic test_load_use();
        drain();
        set_id(1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1);   // LW -> SP
        tick();
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL lu_cnt_before: got %0d expected 0", stall_cnt);
        end
        set_id(1'b1, 4'd9, 1'b1, 4'd1, 1'b1, 1'b0);   // reads SP
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL lu_stall: got %b expected 1", stall);
        end
        tick();
        n_checks++;
        if (stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL lu_cnt_after: got %0d expected 1", stall_cnt);
        end
        n_checks++;
        if (ex_fwd_sel !== 2'b00) begin
            n_fail++; $display("FAIL lu_bubble_fwd: got %b expected 00", ex_fwd_sel);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL lu_stall_once: got %b expected 0", stall);
        end
        tick();
        n_checks++;
        if (ex_fwd_sel !== 2'b10 || stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL lu_reissue: got fwd=%b cnt=%0d expected 10/1",
                               ex_fwd_sel, stall_cnt);
        end
    endtask

    task automatic test_flush();
        drain();
        set_id(1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);   // load -> R2
        tick();
        set_id(1'b1, 4'd2, 1'b1, 4'd1, 1'b1, 1'b0);   // reader of R2
        flush = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: got %b expected 0", stall);
        end
        tick();
        flush = 1'b0;
        #1;
        n_checks++;
        if (ex_fwd_sel !== 2'b00 || stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL flush_fwd: got fwd=%b cnt=%0d expected 00/1",
                               ex_fwd_sel, stall_cnt);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_cleared_e: got stall %b expected 0", stall);
        end
        tick();
        n_checks++;
        if (ex_fwd_sel !== 2'b00) begin
            n_fail++; $display("FAIL flush_killed_load: got %b expected 00", ex_fwd_sel);
        end
    endtask

    // Leaves a load to SP in EX with its dependent (also a load to SP) stalled in ID.
    task automatic test_saturation();
        drain();
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        #1;
        n_checks++;
        if (stall_cnt !== 16'hFFFE) begin
            n_fail++; $display("FAIL sat_preload: got %h expected FFFE", stall_cnt);
        end
        set_id(1'b1, 4'd9, 1'b1, 4'd9, 1'b1, 1'b1);
        tick();                                        // load issues into EX
        tick();                                        // first stall counted
        n_checks++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_first: got %h expected FFFF", stall_cnt);
        end
        tick();                                        // reissue
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL sat_second_stall: got %b expected 1", stall);
        end
        tick();                                        // second stall, saturated
        n_checks++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_hold: got %h expected FFFF", stall_cnt);
        end
        tick();                                        // reissue with WB forward
        n_checks++;
        if (stall !== 1'b1 || ex_fwd_sel !== 2'b10) begin
            n_fail++; $display("FAIL sat_restall: got stall=%b fwd=%b expected 1/10",
                               stall, ex_fwd_sel);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL areset_stall: got %b expected 0", stall);
        end
        n_checks++;
        if (ex_fwd_sel !== 2'b00) begin
            n_fail++; $display("FAIL areset_fwd: got %b expected 00", ex_fwd_sel);
        end
        n_checks++;
        if (stall_cnt !== 16'h0000) begin
            n_fail++; $display("FAIL areset_cnt: got %h expected 0000", stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL areset_load_gone: got stall %b expected 0", stall);
        end
        tick();
        n_checks++;
        if (stall_cnt !== 16'h0000 || ex_fwd_sel !== 2'b00) begin
            n_fail++; $display("FAIL areset_resume: got cnt=%h fwd=%b expected 0000/00",
                               stall_cnt, ex_fwd_sel);
        end
    endtask

    initial begin
        test_reset();
        test_alu_to_alu();
        test_distance_two();
        test_load_use();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
